// File: rtl/ram_port_if.sv
// Controller-side RAM channel set: address, write-data and read-data channels.
// Every channel is valid/ready: a beat transfers on the rising edge where both are high.
interface ram_port_if;
    logic        cntl2ram_a_valid;
    logic        cntl2ram_a_ready;
    logic        cntl2ram_a_write;
    logic [31:0] cntl2ram_a_addr;
    logic        cntl2ram_w_valid;
    logic        cntl2ram_w_ready;
    logic [31:0] cntl2ram_w_data;
    logic        ram2cntl_r_valid;
    logic        ram2cntl_r_ready;
    logic [31:0] ram2cntl_r_data;

    modport master (
        output cntl2ram_a_valid, cntl2ram_a_write, cntl2ram_a_addr,
        output cntl2ram_w_valid, cntl2ram_w_data,
        output ram2cntl_r_ready,
        input  cntl2ram_a_ready, cntl2ram_w_ready,
        input  ram2cntl_r_valid, ram2cntl_r_data
    );

    modport slave (
        input  cntl2ram_a_valid, cntl2ram_a_write, cntl2ram_a_addr,
        input  cntl2ram_w_valid, cntl2ram_w_data,
        input  ram2cntl_r_ready,
        output cntl2ram_a_ready, cntl2ram_w_ready,
        output ram2cntl_r_valid, ram2cntl_r_data
    );
endinterface

// File: rtl/ram_port.sv
// Line-burst bridge from the controller RAM channels to a single-port SRAM with
// one-cycle read latency; a two-entry read FIFO absorbs read-channel backpressure.
module ram_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int BEATS      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ram_port_if.slave             bus,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);
    localparam int LW = $clog2(BEATS);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
    logic                  pending_q, pending_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [31:0]           fifo_q [2];

    logic       a_fire, w_fire, rd_issue, pop, push, fifo_pop;
    logic       write_last, read_done;
    logic [2:0] occ, occ_after;

    logic unused_addr;
    assign unused_addr = ^{bus.cntl2ram_a_addr[31:ADDR_WIDTH+2], bus.cntl2ram_a_addr[LW+1:0]};

    // The beat still in flight from the SRAM counts as an occupied FIFO slot.
    always_comb begin
        a_fire     = (state_q == S_IDLE) && bus.cntl2ram_a_valid;
        w_fire     = (state_q == S_WRITE) && bus.cntl2ram_w_valid;
        occ        = {1'b0, count_q} + {2'b00, pending_q};
        pop        = (occ != 3'd0) && bus.ram2cntl_r_ready;
        occ_after  = occ - {2'b00, pop};
        rd_issue   = (state_q == S_READ) && (beat_cnt_q < BEATS_C) && (occ_after < 3'd2);
        fifo_pop   = pop && (count_q != 2'd0);
        push       = pending_q && !(pop && (count_q == 2'd0));
        write_last = w_fire && (beat_cnt_q == LAST_C);
        read_done  = (state_q == S_READ) && (beat_cnt_q == BEATS_C) && pop && (occ_after == 3'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (a_fire) state_d = bus.cntl2ram_a_write ? S_WRITE : S_READ;
            S_WRITE: if (write_last) state_d = S_IDLE;
            S_READ:  if (read_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // When the FIFO is empty, data returning from the SRAM is presented directly,
    // so the first read beat is visible the cycle after its SRAM access.
    always_comb begin
        bus.cntl2ram_a_ready = (state_q == S_IDLE);
        bus.cntl2ram_w_ready = (state_q == S_WRITE);
        bus.ram2cntl_r_valid = (occ != 3'd0);
        bus.ram2cntl_r_data  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : sram_rdata;
        sram_cs              = w_fire || rd_issue;
        sram_we              = w_fire;
        sram_addr            = base_q + ADDR_WIDTH'(beat_cnt_q);
        sram_wdata           = bus.cntl2ram_w_data;
        busy                 = (state_q != S_IDLE) || (count_q != 2'd0);
        dbg_state_o          = state_q;
    end

    always_comb begin
        base_d     = base_q;
        beat_cnt_d = beat_cnt_q;
        if (a_fire) begin
            base_d     = {bus.cntl2ram_a_addr[ADDR_WIDTH+1:LW+2], {LW{1'b0}}};
            beat_cnt_d = '0;
        end else if (w_fire || rd_issue) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        pending_d = rd_issue;
        count_d   = count_q + {1'b0, push} - {1'b0, fifo_pop};
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ fifo_pop;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            beat_cnt_q <= '0;
            pending_q  <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            base_q     <= base_d;
            beat_cnt_q <= beat_cnt_d;
            pending_q  <= pending_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sram_rdata;
        end
    end
endmodule

// File: tb/tb_ram_port.sv
// Directed bench for ram_port: cycle-vector table for line write/read/alias,
// plus hand-written backpressure, gapped-write and mid-read reset sequences.
module tb_ram_port;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;
    logic          busy;
    logic [1:0]    dbg_state;

    ram_port_if bus();

    ram_port #(.ADDR_WIDTH(AW), .BEATS(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .sram_cs     (sram_cs),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clock = ~clock;

    // SRAM macro model: synchronous write, registered read data.
    logic [31:0] mem [1 << AW];
    always @(posedge clock) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr];
        end
    end

    typedef struct {
        logic          a_valid;
        logic          a_write;
        logic [31:0]   a_addr;
        logic          w_valid;
        logic [31:0]   w_data;
        logic          r_ready;
        logic          e_a_ready;
        logic          e_w_ready;
        logic          e_r_valid;
        logic [31:0]   e_r_data;
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic          e_busy;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, aw, input logic [31:0] aa, input logic wv,
                         input logic [31:0] wd, input logic rr);
        bus.cntl2ram_a_valid = av;
        bus.cntl2ram_a_write = aw;
        bus.cntl2ram_a_addr  = aa;
        bus.cntl2ram_w_valid = wv;
        bus.cntl2ram_w_data  = wd;
        bus.ram2cntl_r_ready = rr;
    endtask

    task automatic add(input logic av, aw, input logic [31:0] aa, input logic wv,
                       input logic [31:0] wd, input logic rr,
                       input logic ear, ewr, erv, input logic [31:0] erd,
                       input logic ecs, ewe, input logic [AW-1:0] ead,
                       input logic [31:0] ewd, input logic ebusy);
        vec_t v;
        v.a_valid = av;  v.a_write = aw;  v.a_addr = aa;
        v.w_valid = wv;  v.w_data = wd;   v.r_ready = rr;
        v.e_a_ready = ear; v.e_w_ready = ewr; v.e_r_valid = erv; v.e_r_data = erd;
        v.e_cs = ecs; v.e_we = ewe; v.e_addr = ead; v.e_wdata = ewd; v.e_busy = ebusy;
        vecs.push_back(v);
    endtask

    // Drains exp_q with r_ready high, then expects the port back in IDLE.
    task automatic drain(input string tag);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(posedge clock); #1;
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            @(negedge clock);
            if (bus.ram2cntl_r_valid)
                check($sformatf("%s_beat", tag), bus.ram2cntl_r_data, exp_q.pop_front());
        end
        check($sformatf("%s_left", tag), 32'(exp_q.size()), 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clock);
        check($sformatf("%s_aready", tag), 32'(bus.cntl2ram_a_ready), 32'd1);
        check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_rd, held_ok, acc, n_wr, idle_wr, got;
        vec_t v;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;

        // Write line at 0x40 (words 0x10..0x13); w_valid while IDLE is ignored.
        add(1,1,32'h40,1,32'hDEADBEEF,0, 1,0,0,32'h0,  0,0,12'h000,32'h0,  0);
        add(0,0,32'h0,1,32'hA0,0,        0,1,0,32'h0,  1,1,12'h010,32'hA0, 1);
        add(0,0,32'h0,1,32'hA1,0,        0,1,0,32'h0,  1,1,12'h011,32'hA1, 1);
        add(0,0,32'h0,1,32'hA2,0,        0,1,0,32'h0,  1,1,12'h012,32'hA2, 1);
        add(0,0,32'h0,1,32'hA3,0,        0,1,0,32'h0,  1,1,12'h013,32'hA3, 1);
        // Read the same line, r_ready always high.
        add(1,0,32'h40,0,32'h0,1,        1,0,0,32'h0,  0,0,12'h000,32'h0,  0);
        add(0,0,32'h0,0,32'h0,1,         0,0,0,32'h0,  1,0,12'h010,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'hA0, 1,0,12'h011,32'h0,  1);
        add(0,0,32'h0,1,32'hBAD,1,       0,0,1,32'hA1, 1,0,12'h012,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'hA2, 1,0,12'h013,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'hA3, 0,0,12'h000,32'h0,  1);
        // Top-of-memory line at 0x3FF0 -> words 0xFFC..0xFFF.
        add(1,1,32'h3FF0,0,32'h0,0,      1,0,0,32'h0,  0,0,12'h000,32'h0,  0);
        add(0,0,32'h0,1,32'h1,0,         0,1,0,32'h0,  1,1,12'hFFC,32'h1,  1);
        add(0,0,32'h0,1,32'h2,0,         0,1,0,32'h0,  1,1,12'hFFD,32'h2,  1);
        add(0,0,32'h0,1,32'h3,0,         0,1,0,32'h0,  1,1,12'hFFE,32'h3,  1);
        add(0,0,32'h0,1,32'h4,0,         0,1,0,32'h0,  1,1,12'hFFF,32'h4,  1);
        // Aliased, unaligned 0x0001_3FF4 reads back the same line from 0xFFC.
        add(1,0,32'h00013FF4,0,32'h0,1,  1,0,0,32'h0,  0,0,12'h000,32'h0,  0);
        add(0,0,32'h0,0,32'h0,1,         0,0,0,32'h0,  1,0,12'hFFC,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'h1,  1,0,12'hFFD,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'h2,  1,0,12'hFFE,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'h3,  1,0,12'hFFF,32'h0,  1);
        add(0,0,32'h0,0,32'h0,1,         0,0,1,32'h4,  0,0,12'h000,32'h0,  1);
        add(0,0,32'h0,0,32'h0,0,         1,0,0,32'h0,  0,0,12'h000,32'h0,  0);

        // Clock/reset: outputs under reset, with a request pending on the bus.
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h0, 1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_a_ready", 32'(bus.cntl2ram_a_ready), 32'd1);
        check("rst_w_ready", 32'(bus.cntl2ram_w_ready), 32'd0);
        check("rst_r_valid", 32'(bus.ram2cntl_r_valid), 32'd0);
        check("rst_cs",      32'(sram_cs), 32'd0);
        check("rst_we",      32'(sram_we), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_state",   32'(dbg_state), 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(posedge clock); #1;
            drive(v.a_valid, v.a_write, v.a_addr, v.w_valid, v.w_data, v.r_ready);
            @(negedge clock);
            check($sformatf("v%0d_a_ready", i), 32'(bus.cntl2ram_a_ready), 32'(v.e_a_ready));
            check($sformatf("v%0d_w_ready", i), 32'(bus.cntl2ram_w_ready), 32'(v.e_w_ready));
            check($sformatf("v%0d_r_valid", i), 32'(bus.ram2cntl_r_valid), 32'(v.e_r_valid));
            check($sformatf("v%0d_cs", i),      32'(sram_cs), 32'(v.e_cs));
            check($sformatf("v%0d_busy", i),    32'(busy), 32'(v.e_busy));
            if (v.e_r_valid) check($sformatf("v%0d_r_data", i), bus.ram2cntl_r_data, v.e_r_data);
            if (v.e_cs) begin
                check($sformatf("v%0d_we", i),   32'(sram_we), 32'(v.e_we));
                check($sformatf("v%0d_addr", i), 32'(sram_addr), 32'(v.e_addr));
                if (v.e_we) check($sformatf("v%0d_wdata", i), sram_wdata, v.e_wdata);
            end
        end

        // Backpressure: r_ready low for 10 cycles after the request.
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0);
        n_rd = 0;
        held_ok = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            @(negedge clock);
            if (sram_cs && !sram_we) n_rd++;
            if (bus.ram2cntl_r_valid && bus.ram2cntl_r_data !== 32'hA0) held_ok = 0;
        end
        check("bp_reads",   32'(n_rd), 32'd2);
        check("bp_hold",    32'(held_ok), 32'd1);
        check("bp_r_valid", 32'(bus.ram2cntl_r_valid), 32'd1);
        check("bp_r_data",  bus.ram2cntl_r_data, 32'hA0);
        exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        drain("bp");

        // Gapped write to 0x80 (words 0x20..0x23), w_valid on odd cycles only.
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        acc = 0;
        n_wr = 0;
        idle_wr = 0;
        for (int k = 0; k < 20 && acc < 4; k++) begin
            @(posedge clock); #1;
            drive(1'b0, 1'b0, 32'h0, k[0], 32'hB0 + 32'(acc), 1'b0);
            @(negedge clock);
            if (sram_cs && sram_we) n_wr++;
            if (k[0]) begin
                check("gap_cs",    32'(sram_cs && sram_we), 32'd1);
                check("gap_addr",  32'(sram_addr), 32'h20 + 32'(acc));
                check("gap_wdata", sram_wdata, 32'hB0 + 32'(acc));
                acc++;
            end else if (sram_cs) begin
                idle_wr++;
            end
        end
        check("gap_writes", 32'(n_wr), 32'd4);
        check("gap_idle",   32'(idle_wr), 32'd0);
        @(posedge clock); #1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF, 1'b0);
        @(negedge clock);
        check("gap_a_ready", 32'(bus.cntl2ram_a_ready), 32'd1);
        check("gap_w_ready", 32'(bus.cntl2ram_w_ready), 32'd0);
        check("gap_stray",   32'(sram_cs), 32'd0);
        for (int i = 0; i < 4; i++) check("gap_mem", mem[32 + i], 32'hB0 + 32'(i));

        // Reset after two beats of a read have been delivered.
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1);
        exp_q = {32'hA0, 32'hA1};
        got = 0;
        for (int k = 0; k < 10 && got < 2; k++) begin
            @(posedge clock); #1;
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            @(negedge clock);
            if (bus.ram2cntl_r_valid) begin
                check("mr_beat", bus.ram2cntl_r_data, exp_q.pop_front());
                got++;
            end
        end
        check("mr_two", 32'(got), 32'd2);
        @(posedge clock); #1;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        check("mr_r_valid", 32'(bus.ram2cntl_r_valid), 32'd0);
        check("mr_a_ready", 32'(bus.cntl2ram_a_ready), 32'd1);
        check("mr_busy",    32'(busy), 32'd0);
        check("mr_cs",      32'(sram_cs), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1);
        exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
        drain("mr_again");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
